// File: rtl/keypad_sequencer.sv
// Four-button keypad entry controller: collects single-button digits, checks them
// against a passcode, and enforces a timed lockout after repeated failures.
module keypad_sequencer #(
  parameter int CODE_LEN    = 4,
  parameter int MAX_FAILS   = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [3:0]            btn_i,
  input  logic [2*CODE_LEN-1:0] passcode_i,
  output logic                  key_valid_o,
  output logic [1:0]            key_idx_o,
  output logic [3:0]            digit_count_o,
  output logic                  unlock_o,
  output logic                  fail_o,
  output logic                  locked_o
);

  localparam int FailW  = $clog2(MAX_FAILS + 1);
  localparam int TimerW = $clog2(LOCK_CYCLES + 1);

  localparam logic [FailW-1:0]  MaxFailsV = FailW'(MAX_FAILS);
  localparam logic [TimerW-1:0] LockLoad  = TimerW'(LOCK_CYCLES);
  localparam logic [3:0]        CodeLenV  = 4'(CODE_LEN);

  typedef enum logic [1:0] {
    COLLECT,
    HELD,
    CHECK,
    LOCKOUT
  } state_e;

  state_e              state_q, state_d;
  logic [3:0]          count_q, count_d;
  logic [FailW-1:0]    fails_q, fails_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [1:0]          entry_q [CODE_LEN];
  logic [1:0]          entry_d [CODE_LEN];
  logic                keyValid_q, keyValid_d;
  logic [1:0]          keyIdx_q, keyIdx_d;
  logic                unlock_q, unlock_d;
  logic                fail_q, fail_d;
  logic                locked_q, locked_d;

  logic                btnSingle;
  logic                btnMulti;
  logic [1:0]          btnDigit;
  logic                entryMatch;
  logic                failNow;
  logic [FailW-1:0]    failsInc;

  // Any pattern with two or more bits set counts as a multi-press.
  always_comb begin
    btnSingle = 1'b0;
    btnMulti  = 1'b0;
    btnDigit  = 2'd0;
    case (btn_i)
      4'b0000: ;
      4'b0001: begin btnSingle = 1'b1; btnDigit = 2'd0; end
      4'b0010: begin btnSingle = 1'b1; btnDigit = 2'd1; end
      4'b0100: begin btnSingle = 1'b1; btnDigit = 2'd2; end
      4'b1000: begin btnSingle = 1'b1; btnDigit = 2'd3; end
      default: btnMulti = 1'b1;
    endcase
  end

  always_comb begin
    entryMatch = 1'b1;
    for (int j = 0; j < CODE_LEN; j++) begin
      if (entry_q[j] != passcode_i[2*j +: 2]) begin
        entryMatch = 1'b0;
      end
    end
  end

  assign failsInc = fails_q + FailW'(1);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    fails_d    = fails_q;
    timer_d    = timer_q;
    entry_d    = entry_q;
    keyValid_d = 1'b0;
    keyIdx_d   = keyIdx_q;
    unlock_d   = 1'b0;
    fail_d     = 1'b0;
    locked_d   = locked_q;
    failNow    = 1'b0;

    case (state_q)
      COLLECT: begin
        if (btnMulti) begin
          failNow = 1'b1;
        end else if (btnSingle) begin
          for (int j = 0; j < CODE_LEN; j++) begin
            if (count_q == 4'(j)) begin
              entry_d[j] = btnDigit;
            end
          end
          count_d    = count_q + 4'd1;
          keyValid_d = 1'b1;
          keyIdx_d   = btnDigit;
          state_d    = HELD;
        end
      end
      HELD: begin
        if (btnMulti) begin
          failNow = 1'b1;
        end else if (!btnSingle) begin
          state_d = (count_q == CodeLenV) ? CHECK : COLLECT;
        end
      end
      CHECK: begin
        if (entryMatch) begin
          unlock_d = 1'b1;
          fails_d  = '0;
          count_d  = 4'd0;
          state_d  = COLLECT;
        end else begin
          failNow = 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_q == TimerW'(1)) begin
          locked_d = 1'b0;
          timer_d  = '0;
          count_d  = 4'd0;
          state_d  = HELD;
        end else begin
          timer_d = timer_q - TimerW'(1);
        end
      end
      default: state_d = COLLECT;
    endcase

    // A failure from a button press parks in HELD so the bad press must be released.
    if (failNow) begin
      fail_d  = 1'b1;
      count_d = 4'd0;
      if (failsInc == MaxFailsV) begin
        fails_d  = '0;
        timer_d  = LockLoad;
        locked_d = 1'b1;
        state_d  = LOCKOUT;
      end else begin
        fails_d = failsInc;
        state_d = (state_q == CHECK) ? COLLECT : HELD;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= COLLECT;
      count_q    <= 4'd0;
      fails_q    <= '0;
      timer_q    <= '0;
      entry_q    <= '{default: 2'b00};
      keyValid_q <= 1'b0;
      keyIdx_q   <= 2'd0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      fails_q    <= fails_d;
      timer_q    <= timer_d;
      entry_q    <= entry_d;
      keyValid_q <= keyValid_d;
      keyIdx_q   <= keyIdx_d;
      unlock_q   <= unlock_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
    end
  end

  assign key_valid_o   = keyValid_q;
  assign key_idx_o     = keyIdx_q;
  assign digit_count_o = count_q;
  assign unlock_o      = unlock_q;
  assign fail_o        = fail_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_keypad_sequencer.sv
// Self-checking bench for keypad_sequencer: directed scenarios plus random stimulus,
// all compared cycle by cycle against a queue-based behavioural model.
module tb_keypad_sequencer;

  localparam int CodeLen    = 4;
  localparam int MaxFails   = 3;
  localparam int LockCycles = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'b0000;
  logic [7:0] passcode = 8'b00_01_10_11;
  logic       keyValid;
  logic [1:0] keyIdx;
  logic [3:0] digitCount;
  logic       unlock;
  logic       fail;
  logic       locked;

  int testsRun = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  keypad_sequencer #(
    .CODE_LEN(CodeLen),
    .MAX_FAILS(MaxFails),
    .LOCK_CYCLES(LockCycles)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .btn_i(btn),
    .passcode_i(passcode),
    .key_valid_o(keyValid),
    .key_idx_o(keyIdx),
    .digit_count_o(digitCount),
    .unlock_o(unlock),
    .fail_o(fail),
    .locked_o(locked)
  );

  wire [9:0] obsVec = {keyValid, keyIdx, digitCount, unlock, fail, locked};

  // Reference model: entered digits as a queue, remaining lockout cycles as a plain
  // countdown, plus flags for "must release first" and "comparison due next cycle".
  int         mDigits[$];
  int         mFails = 0;
  int         mLockRemain = 0;
  bit         mWaitRelease = 1'b0;
  bit         mPendingCheck = 1'b0;
  logic       expKeyValid = 1'b0;
  logic [1:0] expKeyIdx = 2'd0;
  logic       expUnlock = 1'b0;
  logic       expFail = 1'b0;

  logic [3:0] script[$];

  function automatic logic [9:0] expVec();
    return {expKeyValid, expKeyIdx, 4'(mDigits.size()), expUnlock, expFail, (mLockRemain > 0)};
  endfunction

  task automatic modelFail(input bit fromCheck);
    expFail = 1'b1;
    mDigits.delete();
    mFails++;
    if (mFails == MaxFails) begin
      mFails = 0;
      mLockRemain = LockCycles;
      mWaitRelease = 1'b0;
    end else begin
      mWaitRelease = !fromCheck;
    end
  endtask

  task automatic modelStep(input logic [3:0] b, input logic r, input logic [7:0] pc);
    int ones;
    bit match;
    expKeyValid = 1'b0;
    expUnlock = 1'b0;
    expFail = 1'b0;
    ones = $countones(b);
    if (r) begin
      mDigits.delete();
      mFails = 0;
      mLockRemain = 0;
      mWaitRelease = 1'b0;
      mPendingCheck = 1'b0;
      expKeyIdx = 2'd0;
    end else if (mLockRemain > 0) begin
      mLockRemain--;
      if (mLockRemain == 0) mWaitRelease = 1'b1;
    end else if (mPendingCheck) begin
      mPendingCheck = 1'b0;
      match = 1'b1;
      for (int j = 0; j < CodeLen; j++) begin
        if (mDigits[j] != int'((pc >> (2 * j)) & 8'd3)) match = 1'b0;
      end
      if (match) begin
        expUnlock = 1'b1;
        mFails = 0;
        mDigits.delete();
      end else begin
        modelFail(1'b1);
      end
    end else if (ones >= 2) begin
      modelFail(1'b0);
    end else if (mWaitRelease) begin
      if (ones == 0) begin
        mWaitRelease = 1'b0;
        if (mDigits.size() == CodeLen) mPendingCheck = 1'b1;
      end
    end else if (ones == 1) begin
      for (int i = 0; i < 4; i++) begin
        if (b[i]) expKeyIdx = 2'(i);
      end
      mDigits.push_back(int'(expKeyIdx));
      expKeyValid = 1'b1;
      mWaitRelease = 1'b1;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] b, input logic r);
    btn = b;
    rst = r;
    @(posedge clk);
    modelStep(b, r, passcode);
    #1;
  endtask

  task automatic queueDigit(input int d, input int hold, input int gap);
    repeat (hold) script.push_back(4'(1 << d));
    repeat (gap) script.push_back(4'b0000);
  endtask

  task automatic queueEntry(input int d0, input int d1, input int d2, input int d3);
    queueDigit(d0, 3, 2);
    queueDigit(d1, 3, 2);
    queueDigit(d2, 3, 2);
    queueDigit(d3, 3, 2);
  endtask

  task automatic test_reset();
    applyStimulus(4'b0000, 1'b1);
    applyStimulus(4'b0011, 1'b1);
    testsRun++;
    if (obsVec !== 10'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_outputs: got %b, want %b", obsVec, 10'd0);
    end
    testsRun++;
    if (obsVec !== expVec()) begin
      testsFailed++;
      $display("[TB] FAIL reset_model: got %b, want %b", obsVec, expVec());
    end
  endtask

  task automatic test_correct_code();
    int kv = 0, un = 0, fl = 0, unlockAt = -1;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    queueEntry(3, 2, 1, 0);
    repeat (3) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL correct_code step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
      un += int'(unlock);
      fl += int'(fail);
      if (unlock === 1'b1) unlockAt = i;
    end
    testsRun++;
    if (kv != 4 || un != 1 || fl != 0 || unlockAt != 19) begin
      testsFailed++;
      $display("[TB] FAIL correct_code_tally: got kv=%0d un=%0d fl=%0d at=%0d, want 4 1 0 19",
               kv, un, fl, unlockAt);
    end
  endtask

  task automatic test_wrong_code();
    int kv = 0, un = 0, fl = 0, lk = 0;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    queueEntry(0, 0, 0, 0);
    repeat (2) script.push_back(4'b0000);
    queueEntry(3, 2, 1, 0);
    repeat (2) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL wrong_code step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
      un += int'(unlock);
      fl += int'(fail);
      lk += int'(locked);
    end
    testsRun++;
    if (kv != 8 || un != 1 || fl != 1 || lk != 0) begin
      testsFailed++;
      $display("[TB] FAIL wrong_code_tally: got kv=%0d un=%0d fl=%0d lk=%0d, want 8 1 1 0",
               kv, un, fl, lk);
    end
  endtask

  task automatic test_multi_press();
    int kv = 0, un = 0, fl = 0, failAt = -1;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    queueDigit(3, 3, 2);
    queueDigit(2, 3, 2);
    script.push_back(4'b0011);
    repeat (4) script.push_back(4'b0001);
    repeat (2) script.push_back(4'b0000);
    queueEntry(3, 2, 1, 0);
    repeat (2) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL multi_press step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
      un += int'(unlock);
      fl += int'(fail);
      if (fail === 1'b1) failAt = i;
    end
    testsRun++;
    if (kv != 6 || un != 1 || fl != 1 || failAt != 10) begin
      testsFailed++;
      $display("[TB] FAIL multi_press_tally: got kv=%0d un=%0d fl=%0d at=%0d, want 6 1 1 10",
               kv, un, fl, failAt);
    end
  endtask

  task automatic test_held_button();
    int kv = 0;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    repeat (20) script.push_back(4'b0100);
    repeat (5) script.push_back(4'b0010);
    repeat (3) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL held_button step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
    end
    testsRun++;
    if (kv != 1 || keyIdx !== 2'd2 || digitCount !== 4'd1) begin
      testsFailed++;
      $display("[TB] FAIL held_button_tally: got kv=%0d idx=%0d cnt=%0d, want 1 2 1",
               kv, keyIdx, digitCount);
    end
  endtask

  task automatic test_lockout();
    int kv = 0, un = 0, fl = 0, lk = 0;
    logic [3:0] noise[4];
    noise = '{4'b1000, 4'b0011, 4'b1111, 4'b0000};
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    repeat (3) queueEntry(0, 0, 0, 0);
    for (int k = 0; k < LockCycles; k++) script.push_back(noise[k % 4]);
    repeat (6) script.push_back(4'b0001);
    repeat (2) script.push_back(4'b0000);
    queueEntry(3, 2, 1, 0);
    repeat (2) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL lockout step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
      un += int'(unlock);
      fl += int'(fail);
      lk += int'(locked);
    end
    testsRun++;
    if (kv != 16 || un != 1 || fl != 3 || lk != LockCycles) begin
      testsFailed++;
      $display("[TB] FAIL lockout_tally: got kv=%0d un=%0d fl=%0d lk=%0d, want 16 1 3 %0d",
               kv, un, fl, lk, LockCycles);
    end
  endtask

  task automatic test_reset_midop();
    int un = 0;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    queueDigit(3, 3, 2);
    queueDigit(2, 3, 2);
    queueDigit(1, 3, 0);
    foreach (script[i]) applyStimulus(script[i], 1'b0);
    applyStimulus(4'b0100, 1'b1);
    testsRun++;
    if (obsVec !== 10'd0 || obsVec !== expVec()) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_entry: got %b, want %b", obsVec, 10'd0);
    end
    script.delete();
    repeat (3) queueEntry(1, 1, 1, 1);
    repeat (5) script.push_back(4'b0010);
    foreach (script[i]) applyStimulus(script[i], 1'b0);
    testsRun++;
    if (locked !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL reset_pre_lock: got locked=%b, want 1", locked);
    end
    applyStimulus(4'b0000, 1'b1);
    testsRun++;
    if (obsVec !== 10'd0 || obsVec !== expVec()) begin
      testsFailed++;
      $display("[TB] FAIL reset_mid_lockout: got %b, want %b", obsVec, 10'd0);
    end
    script.delete();
    queueEntry(3, 2, 1, 0);
    repeat (2) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL reset_midop step %0d: got %b, want %b", i, obsVec, expVec());
      end
      un += int'(unlock);
    end
    testsRun++;
    if (un != 1) begin
      testsFailed++;
      $display("[TB] FAIL reset_midop_unlock: got %0d, want 1", un);
    end
  endtask

  task automatic test_back_to_back();
    int kv = 0, un = 0, fl = 0;
    applyStimulus(4'b0000, 1'b1);
    script.delete();
    queueEntry(3, 2, 1, 0);
    queueEntry(3, 2, 1, 0);
    queueEntry(1, 1, 1, 1);
    queueEntry(3, 2, 1, 0);
    repeat (2) script.push_back(4'b0000);
    foreach (script[i]) begin
      applyStimulus(script[i], 1'b0);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL back_to_back step %0d: got %b, want %b", i, obsVec, expVec());
      end
      kv += int'(keyValid);
      un += int'(unlock);
      fl += int'(fail);
    end
    testsRun++;
    if (kv != 16 || un != 3 || fl != 1) begin
      testsFailed++;
      $display("[TB] FAIL back_to_back_tally: got kv=%0d un=%0d fl=%0d, want 16 3 1", kv, un, fl);
    end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic       r;
    int         sel;
    applyStimulus(4'b0000, 1'b1);
    for (int i = 0; i < 1500; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 45) begin
        b = 4'b0000;
      end else if (sel < 88) begin
        b = 4'(1 << $urandom_range(0, 3));
      end else begin
        b = 4'($urandom_range(3, 15));
        while ($countones(b) < 2) b = 4'($urandom_range(3, 15));
      end
      r = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 49) == 0) passcode = 8'($urandom_range(0, 255));
      applyStimulus(b, r);
      testsRun++;
      if (obsVec !== expVec()) begin
        testsFailed++;
        $display("[TB] FAIL random step %0d btn=%b: got %b, want %b", i, b, obsVec, expVec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_multi_press();
    test_held_button();
    test_lockout();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/keypad_sequencer.md
# keypad_sequencer

Sequencing controller for the four-button entry pad. Accepts single-button presses one at a time, rejects simultaneous multi-button presses, assembles a CODE_LEN-digit entry, compares it against a passcode, and applies a timed lockout after repeated failures. Sits between the debounced button inputs and the door/unlock logic. Its multi-press rule matches the team's invalid-input detector: any two or more bits of btn high.

## Interface

- CODE_LEN, 4: digits per entry, range 1–8.
- MAX_FAILS, 3: consecutive failures that trigger lockout, at least 1.
- LOCK_CYCLES, 16: lockout duration in clock cycles, at least 1.

- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- btn  in  4  debounced, synchronised buttons; btn[i] high = button i held.
- passcode  in  2*CODE_LEN  expected code; digit j in bits [2j+1:2j], digit 0 entered first.
- key_valid  out  1  one-cycle pulse when a digit is accepted.
- key_idx  out  2  accepted digit (button index); valid while key_valid is high, otherwise holds its last value.
- digit_count  out  4  digits collected in the current entry.
- unlock  out  1  one-cycle pulse when the entry matches.
- fail  out  1  one-cycle pulse on mismatch or multi-press.
- locked  out  1  high during lockout.

Every output is registered. After reset, every output is 0.

## Operation

- Classification each cycle: none = btn==0; single = exactly one bit set; multi = two or more bits set. The digit value for a single press is the index of the set bit.
- States: COLLECT, HELD, CHECK, LOCKOUT. Reset state is COLLECT, with count=0, fails=0, timer=0.
- COLLECT:
  - single: store the digit at position count, increment count, pulse key_valid, go to HELD.
  - multi: take the failure path.
  - none: stay in COLLECT.
- HELD (waiting for full release):
  - multi: take the failure path.
  - none with count==CODE_LEN: go to CHECK.
  - none with count<CODE_LEN: go to COLLECT.
  - single: stay in HELD. A held or changed single button does not produce a new digit.
- CHECK (exactly one cycle): compare the entered digits with passcode, sampled in this cycle only.
  - Match: pulse unlock, set fails=0, set count=0, go to COLLECT.
  - Mismatch: take the failure path.
- Failure path:
  - Pulse fail, set count=0, increment fails.
  - If the new fails value equals MAX_FAILS: go to LOCKOUT, load timer=LOCK_CYCLES, set locked=1, clear fails.
  - Otherwise, coming from CHECK: go to COLLECT.
  - Otherwise, coming from COLLECT or HELD: go to HELD, so the bad press must be fully released first.
- LOCKOUT:
  - btn is ignored; no key_valid is issued.
  - timer decrements each cycle. When timer reaches 1, the next edge clears locked and moves to HELD with count=0.
  - This forces a full release before a new entry can start.
- Partial entries have no timeout.
- rst at any point, including mid-entry or mid-lockout: returns to the reset state on the next edge, dropping any partial entry and any pending pulse.

## Timing

- Single press sampled at edge k in COLLECT: key_valid, key_idx and digit_count update at edge k; HELD is entered at edge k.
- Final release sampled at edge k in HELD: CHECK is entered at edge k; unlock or fail is high for the one cycle after edge k+1.
- Multi-press sampled at edge k: fail is high for the one cycle after edge k.
- Lockout: locked rises at the edge that registers the MAX_FAILS-th failure. It stays high for exactly LOCK_CYCLES cycles.
- Back-to-back entries: the earliest next digit is accepted 2 cycles after unlock or fail (CHECK→COLLECT, then sample).
- fails wraps only through lockout; it never exceeds MAX_FAILS-1 outside LOCKOUT.

## Test plan

- Correct code: passcode=8'b00_01_10_11; press btn 1000, 0100, 0010, 0001, each 3 cycles held with 2 released cycles between -> key_idx 3,2,1,0; digit_count 1..4; unlock pulse 1 cycle, 2 cycles after the final release; fail=0.
- Wrong code: the same passcode, entry 0,0,0,0 -> fail pulse, digit_count back to 0, locked=0; a following correct entry -> unlock.
- Multi-press: btn=0011 after 2 good digits -> fail pulse next cycle, count=0; holding 0001 afterward gives no key_valid until btn returns to 0000.
- Lockout: 3 wrong entries with MAX_FAILS=3, LOCK_CYCLES=16 -> locked high for exactly 16 cycles; presses during lockout produce no key_valid; after lockout, with btn held, nothing happens until release; then a correct entry gives unlock.
- Held button: 0100 held for 20 cycles -> exactly one key_valid; switching directly to 0010 without release -> no new digit.
- Reset mid-op: rst after 3 digits, and again mid-lockout -> next cycle all outputs 0, digit_count 0, locked 0; a fresh correct entry unlocks.
